// File: rtl/cve2_register_file_mp.sv
// -----------------------------------------------------------------------------
// cve2_register_file_mp
//
// Multi-port flip-flop register file with a pending-write (busy) scoreboard for
// the CVE2 dual-issue / out-of-order writeback pipeline.
//
// Registers x1..x(NumWords-1) live in flops. There is no storage for x0: it
// always reads WordZeroVal and is never busy. NumWords is 16 when RV32E is set
// and 32 otherwise. With RV32E, any access whose address has bit 4 set is
// ignored, and a read at such an address returns WordZeroVal, not busy.
//
// Write ports are prioritised by index: when several enabled ports target the
// same register, the highest-index port wins. A reserve marks a register busy
// at issue, and any enabled write to it clears the busy bit at writeback. If a
// reserve and a write hit the same register in one cycle, the register stays
// busy and the data is still written.
//
// Optional feature (compile-time macro):
//   CVE2_RF_BYPASS_EN - write-through forwarding. A read of a register that an
//                       enabled write port targets in the same cycle returns
//                       that port's data. It reports not busy, unless the
//                       register is also being reserved in that cycle.
//                       This adds a combinational path from we_i/wdata_i to
//                       rdata_o. When the macro is undefined, reads see the
//                       flop contents only.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          asynchronous active-high reset, clears data, busy bits and
//                  the conflict flag
//   raddr_i        read addresses, port r at [5r+:5]
//   rdata_o        read data, port r at [DataWidth*r+:DataWidth]
//   rbusy_o        per read port, 1 = the addressed register has a write pending
//   waddr_i        write addresses, port w at [5w+:5]
//   wdata_i        write data, port w at [DataWidth*w+:DataWidth]
//   we_i           write enables, one per write port
//   rsv_valid_i    reserve request
//   rsv_addr_i     register to mark busy
//   wr_conflict_o  one-cycle pulse: in the previous cycle, two or more enabled
//                  write ports targeted the same valid non-zero register
// -----------------------------------------------------------------------------
module cve2_register_file_mp #(
  parameter bit                   RV32E         = 1'b0,
  parameter int                   DataWidth     = 32,
  parameter int                   NumReadPorts  = 2,
  parameter int                   NumWritePorts = 2,
  parameter logic [DataWidth-1:0] WordZeroVal   = '0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NumReadPorts*5-1:0]          raddr_i,
  output logic [NumReadPorts*DataWidth-1:0]  rdata_o,
  output logic [NumReadPorts-1:0]            rbusy_o,
  input  logic [NumWritePorts*5-1:0]         waddr_i,
  input  logic [NumWritePorts*DataWidth-1:0] wdata_i,
  input  logic [NumWritePorts-1:0]           we_i,
  input  logic                               rsv_valid_i,
  input  logic [4:0]                         rsv_addr_i,
  output logic                               wr_conflict_o
);

  localparam int NumWords = RV32E ? 16 : 32;
  localparam int AddrW    = 5;

  // x0 is not writable. Under RV32E, an address with bit 4 set is also not
  // writable.
  function automatic logic addr_writable(input logic [AddrW-1:0] addr);
    return (addr != '0) && !(RV32E && addr[AddrW-1]);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: per-register decode of the write ports and the reserve port.
  // Only addresses 1..NumWords-1 are decoded. Under RV32E, a 5-bit address
  // with bit 4 set cannot equal any index below 16, so such accesses fall out
  // of the decode without further gating.
  // ---------------------------------------------------------------------------
  logic [NumWords-1:1] we_dec_p0;
  logic [NumWords-1:1] rsv_dec_p0;
  logic [DataWidth-1:0] wdata_dec_p0 [1:NumWords-1];
  logic                 conflict_p0;

  always_comb begin
    we_dec_p0  = '0;
    rsv_dec_p0 = '0;
    for (int i = 1; i < NumWords; i++) begin
      wdata_dec_p0[i] = '0;
    end
    for (int i = 1; i < NumWords; i++) begin
      // Ascending scan: a later (higher-index) port overrides an earlier one.
      for (int w = 0; w < NumWritePorts; w++) begin
        if (we_i[w] && (waddr_i[AddrW*w +: AddrW] == AddrW'(i))) begin
          we_dec_p0[i]    = 1'b1;
          wdata_dec_p0[i] = wdata_i[DataWidth*w +: DataWidth];
        end
      end
      rsv_dec_p0[i] = rsv_valid_i && (rsv_addr_i == AddrW'(i));
    end
  end

  // Pairwise write-address collision. This is a diagnostic only; the write
  // itself still resolves by port priority.
  always_comb begin
    conflict_p0 = 1'b0;
    for (int a = 0; a < NumWritePorts; a++) begin
      for (int b = a + 1; b < NumWritePorts; b++) begin
        if (we_i[a] && we_i[b] &&
            (waddr_i[AddrW*a +: AddrW] == waddr_i[AddrW*b +: AddrW]) &&
            addr_writable(waddr_i[AddrW*a +: AddrW])) begin
          conflict_p0 = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: architectural state (register contents, busy bits, conflict flag)
  // ---------------------------------------------------------------------------
  logic [DataWidth-1:0] rf_p1 [1:NumWords-1];
  logic [NumWords-1:1]  busy_p1;
  logic                 conflict_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 1; i < NumWords; i++) begin
        rf_p1[i] <= WordZeroVal;
      end
    end else begin
      for (int i = 1; i < NumWords; i++) begin
        if (we_dec_p0[i]) begin
          rf_p1[i] <= wdata_dec_p0[i];
        end
      end
    end
  end

  // Reserve takes precedence over writeback. An instruction that issues in the
  // same cycle as an older writeback to the same register still owns the
  // register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_p1     <= '0;
      conflict_p1 <= 1'b0;
    end else begin
      for (int i = 1; i < NumWords; i++) begin
        if (rsv_dec_p0[i]) begin
          busy_p1[i] <= 1'b1;
        end else if (we_dec_p0[i]) begin
          busy_p1[i] <= 1'b0;
        end
      end
      conflict_p1 <= conflict_p0;
    end
  end

  assign wr_conflict_o = conflict_p1;

  // ---------------------------------------------------------------------------
  // Read ports: combinational select from the p1 state. Address 0 and, under
  // RV32E, addresses with bit 4 set match no index, so they keep the defaults
  // of WordZeroVal and not busy.
  // ---------------------------------------------------------------------------
  logic [DataWidth-1:0] rd_data [NumReadPorts];
  logic                 rd_busy [NumReadPorts];

  always_comb begin
    for (int r = 0; r < NumReadPorts; r++) begin
      rd_data[r] = WordZeroVal;
      rd_busy[r] = 1'b0;
      for (int i = 1; i < NumWords; i++) begin
        if (raddr_i[AddrW*r +: AddrW] == AddrW'(i)) begin
`ifdef CVE2_RF_BYPASS_EN
          if (we_dec_p0[i]) begin
            rd_data[r] = wdata_dec_p0[i];
            rd_busy[r] = rsv_dec_p0[i];
          end else begin
            rd_data[r] = rf_p1[i];
            rd_busy[r] = busy_p1[i];
          end
`else
          rd_data[r] = rf_p1[i];
          rd_busy[r] = busy_p1[i];
`endif
        end
      end
    end
  end

  for (genvar r = 0; r < NumReadPorts; r++) begin : g_rd
    assign rdata_o[DataWidth*r +: DataWidth] = rd_data[r];
    assign rbusy_o[r]                        = rd_busy[r];
  end

endmodule

// File: tb/tb_cve2_register_file_mp.sv
module tb_cve2_register_file_mp;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic [9:0]  raddr     = '0;
  logic [9:0]  waddr     = '0;
  logic [63:0] wdata     = '0;
  logic [1:0]  we        = '0;
  logic        rsv_valid = 1'b0;
  logic [4:0]  rsv_addr  = '0;

  logic [63:0] rdata, rdata_e;
  logic [1:0]  rbusy, rbusy_e;
  logic        conf, conf_e;

  always #5 clk = ~clk;

  cve2_register_file_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2), .WordZeroVal(32'h0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_valid_i(rsv_valid),
    .rsv_addr_i(rsv_addr), .wr_conflict_o(conf)
  );

  cve2_register_file_mp #(
    .RV32E(1'b1), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2), .WordZeroVal(32'h0)
  ) dut_e (
    .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_e), .rbusy_o(rbusy_e),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_valid_i(rsv_valid),
    .rsv_addr_i(rsv_addr), .wr_conflict_o(conf_e)
  );

  // Scoreboard entry: kind 0 = read port check, kind 1 = wr_conflict_o check.
  typedef struct packed {
    logic        inst;   // 0 = dut (RV32I), 1 = dut_e (RV32E)
    logic        kind;
    logic [1:0]  port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t  sbq[$];
  string snq[$];
  int    checks = 0;
  int    errors = 0;

  exp_t        e;
  string       en;
  logic [31:0] ad;
  logic        ab;

  function automatic logic [31:0] fv(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
  endfunction

  task automatic push_rd(input string n, input bit inst, input int port,
                         input logic [31:0] d, input logic b);
    exp_t x;
    x.inst = inst; x.kind = 1'b0; x.port = 2'(port); x.data = d; x.busy = b;
    sbq.push_back(x);
    snq.push_back(n);
  endtask

  task automatic push_cf(input string n, input bit inst, input logic c);
    exp_t x;
    x.inst = inst; x.kind = 1'b1; x.port = 2'd0; x.data = {31'b0, c}; x.busy = 1'b0;
    sbq.push_back(x);
    snq.push_back(n);
  endtask

  // Pops one expectation and fetches the matching DUT observation.
  task sb_pop;
    e  = sbq.pop_front();
    en = snq.pop_front();
    if (e.kind) begin
      ad = {31'b0, (e.inst ? conf_e : conf)};
      ab = 1'b0;
    end else if (e.inst) begin
      ad = rdata_e[32*e.port +: 32];
      ab = rbusy_e[e.port];
    end else begin
      ad = rdata[32*e.port +: 32];
      ab = rbusy[e.port];
    end
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    waddr[5*p +: 5] = a;
    wdata[32*p +: 32] = d;
    we[p] = 1'b1;
  endtask

  task automatic rd(input int p, input logic [4:0] a);
    raddr[5*p +: 5] = a;
  endtask

  task automatic idle;
    we = '0;
    rsv_valid = 1'b0;
  endtask

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task test_reset;
    #1 rst = 1'b1;
    rd(0, 5'd0); rd(1, 5'd5);
    #1;
    push_rd("rst_x0", 0, 0, 32'h0, 1'b0);
    push_rd("rst_x5", 0, 1, 32'h0, 1'b0);
    push_cf("rst_conflict", 0, 1'b0);
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    // Write and reserve while reset is held: both must be ignored.
    wr(0, 5'd5, 32'hAAAA_AAAA); rsv_valid = 1'b1; rsv_addr = 5'd5;
    push_rd("rst_hold_wr_x5", 0, 1, 32'h0, 1'b0);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    idle();
    rst = 1'b0;
    push_rd("post_rst_x5", 0, 1, 32'h0, 1'b0);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
  endtask

  task test_x0;
    // Both ports write x0 with different data, plus a reserve of x0.
    wr(0, 5'd0, 32'hDEAD_BEEF); wr(1, 5'd0, 32'h1234_5678);
    rsv_valid = 1'b1; rsv_addr = 5'd0;
    rd(0, 5'd0);
    push_rd("x0_read", 0, 0, 32'h0, 1'b0);
    push_cf("x0_no_conflict", 0, 1'b0);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    idle();
  endtask

  task test_priority;
    wr(0, 5'd7, 32'h0000_1111); wr(1, 5'd7, 32'h0000_2222);
    rd(0, 5'd7);
    push_rd("prio_x7", 0, 0, 32'h0000_2222, 1'b0);
    push_cf("prio_conflict_hi", 0, 1'b1);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    idle();
    push_cf("prio_conflict_lo", 0, 1'b0);
    push_rd("prio_x7_hold", 0, 0, 32'h0000_2222, 1'b0);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
  endtask

  task test_scoreboard;
    rsv_valid = 1'b1; rsv_addr = 5'd3;
    rd(1, 5'd3);
    push_rd("sb_busy_set_c1", 0, 1, 32'h0, 1'b1);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    idle();
    for (int c = 2; c <= 4; c++) begin
      push_rd($sformatf("sb_busy_hold_c%0d", c), 0, 1, 32'h0, 1'b1);
      cyc();
      while (sbq.size() != 0) begin
        sb_pop(); checks++;
        if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
      end
    end
    wr(0, 5'd3, 32'h0000_A5A5);
    push_rd("sb_wb_clear_c5", 0, 1, 32'h0000_A5A5, 1'b0);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    idle();
    // Reserve and write together: the reserve wins, and the data still lands.
    wr(1, 5'd3, 32'h0000_5A5A); rsv_valid = 1'b1; rsv_addr = 5'd3;
    push_rd("sb_rsv_and_wr", 0, 1, 32'h0000_5A5A, 1'b1);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    idle();
  endtask

  task test_bypass;
    wr(0, 5'd9, 32'h1111_2222);
    cyc();
    idle();
    // Write x9 and read x9 in the same cycle, sampled before the edge.
    rd(0, 5'd9);
    wr(1, 5'd9, 32'h0BAD_F00D);
    #1;
`ifdef CVE2_RF_BYPASS_EN
    push_rd("byp_same_cycle", 0, 0, 32'h0BAD_F00D, 1'b0);
`else
    push_rd("byp_same_cycle", 0, 0, 32'h1111_2222, 1'b0);
`endif
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    push_rd("byp_next_cycle", 0, 0, 32'h0BAD_F00D, 1'b0);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    idle();
    // Write and reserve x9 in the same cycle, read x9 before the edge.
    wr(0, 5'd9, 32'h0000_5555); rsv_valid = 1'b1; rsv_addr = 5'd9;
    #1;
`ifdef CVE2_RF_BYPASS_EN
    push_rd("byp_rsv_same_cycle", 0, 0, 32'h0000_5555, 1'b1);
`else
    push_rd("byp_rsv_same_cycle", 0, 0, 32'h0BAD_F00D, 1'b0);
`endif
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    push_rd("byp_rsv_next_cycle", 0, 0, 32'h0000_5555, 1'b1);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    idle();
  endtask

  task test_rv32e;
    wr(0, 5'd1, 32'h0000_CAFE);
    rd(0, 5'd1);
    push_rd("e_x1_write", 1, 0, 32'h0000_CAFE, 1'b0);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    idle();
    // x17 is out of range for RV32E; it must not alias onto x1.
    wr(0, 5'd17, 32'h0000_1234); rsv_valid = 1'b1; rsv_addr = 5'd17;
    rd(1, 5'd17);
    push_rd("e_x1_untouched", 1, 0, 32'h0000_CAFE, 1'b0);
    push_rd("e_x17_ignored", 1, 1, 32'h0, 1'b0);
    push_rd("i_x1_untouched", 0, 0, 32'h0000_CAFE, 1'b0);
    push_rd("i_x17_written", 0, 1, 32'h0000_1234, 1'b1);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    idle();
  endtask

  task test_async_reset;
    for (int i = 1; i <= 31; i += 2) begin
      wr(0, 5'(i), fv(i));
      if (i < 31) wr(1, 5'(i + 1), fv(i + 1));
      else we[1] = 1'b0;
      cyc();
    end
    idle();
    rsv_valid = 1'b1; rsv_addr = 5'd4;
    rd(0, 5'd4); rd(1, 5'd31);
    push_rd("fill_x4_busy", 0, 0, fv(4), 1'b1);
    push_rd("fill_x31", 0, 1, fv(31), 1'b0);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    idle();
    // Raise reset between edges; the state must clear before any edge.
    #2 rst = 1'b1;
    #1;
    push_rd("arst_x4", 0, 0, 32'h0, 1'b0);
    push_rd("arst_x31", 0, 1, 32'h0, 1'b0);
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
    for (int i = 1; i <= 31; i++) begin
      rd(0, 5'(i)); rd(1, 5'(32 - i));
      #1;
      push_rd($sformatf("arst_p0_x%0d", i), 0, 0, 32'h0, 1'b0);
      push_rd($sformatf("arst_p1_x%0d", 32 - i), 0, 1, 32'h0, 1'b0);
      while (sbq.size() != 0) begin
        sb_pop(); checks++;
        if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    rd(0, 5'd4);
    push_rd("arst_release_x4", 0, 0, 32'h0, 1'b0);
    push_cf("arst_release_conflict", 0, 1'b0);
    cyc();
    while (sbq.size() != 0) begin
      sb_pop(); checks++;
      if (ad !== e.data || ab !== e.busy) begin errors++; $display("FAIL %s: got data=%h busy=%b want data=%h busy=%b", en, ad, ab, e.data, e.busy); end
    end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_priority();
    test_scoreboard();
    test_bypass();
    test_rv32e();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
